// File: rtl/ehl_cdc_pkg.sv
// ehl_cdc_pkg: shared constants and helpers for the ehl FIFO read path.
package ehl_cdc_pkg;
  localparam int EHL_RD_LAT_MAX = 3;
  function automatic int ehl_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ehl_fifo_rd_prefetch_if.sv
// ehl_fifo_rd_prefetch_if: first-word-fall-through valid/ready stream.
interface ehl_fifo_rd_prefetch_if #(parameter int DATA_WIDTH = 8);
  logic valid;
  logic ready;
  logic [DATA_WIDTH-1:0] data;
  modport master(output valid, output data, input ready);
  modport slave(input valid, input data, output ready);
endinterface

// File: rtl/ehl_fifo_rd_prefetch_skid.sv
// ehl_fifo_rd_skid: circular landing buffer for prefetched FIFO words; depth need not be a power of two.
module ehl_fifo_rd_skid import ehl_cdc_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic                  rclk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [CNT_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int PW = ehl_clog2(DEPTH);
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  always_comb begin
    wptr_d = clr ? '0 : push ? (wptr_q == PW'(DEPTH - 1) ? '0 : wptr_q + PW'(1)) : wptr_q;
    rptr_d = clr ? '0 : pop ? (rptr_q == PW'(DEPTH - 1) ? '0 : rptr_q + PW'(1)) : rptr_q;
    occ_d = clr ? '0 : occ_q + CNT_W'(push) - CNT_W'(pop);
    mem_d = mem_q;
    if (push && !clr) mem_d[wptr_q] = wdata;
  end
  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q <= occ_d;
      mem_q <= mem_d;
    end
  end
  assign occ = occ_q;
  assign rdata = mem_q[rptr_q];
endmodule

// File: rtl/ehl_fifo_rd_prefetch.sv
// ehl_fifo_rd_prefetch: async-FIFO read-side prefetcher hiding RD_LATENCY behind a FWFT stream.
// EHL_FIFO_RD_PREFETCH_FLUSH_EN adds a synchronous flush that discards buffered and in-flight words.
module ehl_fifo_rd_prefetch import ehl_cdc_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  localparam int SKID_DEPTH = RD_LATENCY + 2,
  localparam int CNT_W = ehl_clog2(SKID_DEPTH + 1)
) (
  input  logic                  rclk,
  input  logic                  reset_n,
  output logic                  fifo_rd,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  ehl_fifo_rd_prefetch_if.master m,
`ifdef EHL_FIFO_RD_PREFETCH_FLUSH_EN
  input  logic                  flush,
`endif
  output logic [CNT_W-1:0]      level
);
  localparam int TW = RD_LATENCY > 0 ? RD_LATENCY : 1;
  if (RD_LATENCY < 0 || RD_LATENCY > EHL_RD_LAT_MAX) begin : g_bad_lat
    $error("RD_LATENCY out of range");
  end
  logic clr, push;
  logic [TW-1:0] tag_q, tag_d, live;
  logic [CNT_W-1:0] occ, inflight;
  logic [DATA_WIDTH-1:0] rdata;
`ifdef EHL_FIFO_RD_PREFETCH_FLUSH_EN
  logic [TW-1:0] disc_q, disc_d;
  assign clr = flush;
  assign live = tag_q & ~disc_q;
  always_comb disc_d = RD_LATENCY == 0 ? '0 : (disc_q | (flush ? tag_q : '0)) << 1;
  always_ff @(posedge rclk or negedge reset_n)
    if (!reset_n) disc_q <= '0;
    else disc_q <= disc_d;
`else
  assign clr = 1'b0;
  assign live = tag_q;
`endif
  // Issue is gated only by registered state, so m_ready never reaches fifo_rd.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(live[i]);
    fifo_rd = reset_n && !clr && !fifo_empty && (occ + inflight < CNT_W'(SKID_DEPTH));
    tag_d = RD_LATENCY == 0 ? '0 : (tag_q << 1) | TW'(fifo_rd);
    push = RD_LATENCY == 0 ? fifo_rd : live[TW-1];
    level = occ + inflight;
  end
  always_ff @(posedge rclk or negedge reset_n)
    if (!reset_n) tag_q <= '0;
    else tag_q <= tag_d;
  ehl_fifo_rd_skid #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(SKID_DEPTH), .CNT_W(CNT_W)) u_skid (
    .rclk(rclk),
    .reset_n(reset_n),
    .clr(clr),
    .push(push),
    .pop(m.valid && m.ready),
    .wdata(fifo_rdata),
    .occ(occ),
    .rdata(rdata)
  );
  assign m.valid = occ != '0;
  assign m.data = rdata;
endmodule

// File: tb/tb_ehl_fifo_rd_prefetch.sv
// tb_ehl_fifo_rd_prefetch: directed bench over RD_LATENCY 0..3 with a behavioural read-controller model.
module tb_ehl_fifo_rd_prefetch;
  localparam int NK = 4;
  typedef struct {
    logic hold;
    logic exp_rd;
    logic exp_valid;
    int   exp_data;
    int   exp_level;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold [NK];
  logic m_ready [NK];
`ifdef EHL_FIFO_RD_PREFETCH_FLUSH_EN
  logic flush [NK];
`endif
  logic fifo_rd [NK];
  logic fifo_empty [NK];
  logic [7:0] fifo_rdata [NK];
  logic m_valid [NK];
  logic [7:0] m_data [NK];
  logic [3:0] level [NK];
  logic [7:0] words [NK][256];
  int loaded [NK];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NK; g++) begin : gd
    localparam int CW = $clog2(g + 3);
    logic [CW-1:0] lvl;
    logic [7:0] pipe [4];
    int rd_cnt = 0;
    int pulses = 0;
    logic uf = 1'b0;
    ehl_fifo_rd_prefetch_if #(.DATA_WIDTH(8)) sif ();
    ehl_fifo_rd_prefetch #(.DATA_WIDTH(8), .RD_LATENCY(g)) dut (
      .rclk(clk),
      .reset_n(rst_n),
      .fifo_rd(fifo_rd[g]),
      .fifo_empty(fifo_empty[g]),
      .fifo_rdata(fifo_rdata[g]),
      .m(sif),
`ifdef EHL_FIFO_RD_PREFETCH_FLUSH_EN
      .flush(flush[g]),
`endif
      .level(lvl)
    );
    assign sif.ready = m_ready[g];
    assign m_valid[g] = sif.valid;
    assign m_data[g] = sif.data;
    assign level[g] = 4'(lvl);
    assign fifo_empty[g] = hold[g] || rd_cnt >= loaded[g];
    if (g == 0) begin : g_comb
      assign fifo_rdata[g] = words[g][8'(rd_cnt)];
    end else begin : g_pipe
      assign fifo_rdata[g] = pipe[g-1];
    end
    // Memory model: word read on fifo_rd emerges g cycles later; junk otherwise.
    always @(posedge clk) begin
      if (fifo_rd[g]) begin
        rd_cnt <= rd_cnt + 1;
        pulses <= pulses + 1;
      end
      if (fifo_rd[g] && fifo_empty[g]) uf <= 1'b1;
      pipe[0] <= fifo_rd[g] ? words[g][8'(rd_cnt)] : 8'hEE;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int k, input int n, input int first);
    for (int i = 0; i < n; i++) words[k][loaded[k] + i] = 8'(first + i);
    loaded[k] += n;
  endtask
  vec_t tv [8];
  int sb [NK];
  int nextw [NK];
  int n;
  bit seen;
  initial begin
    tv[0] = '{1'b0, 1'b1, 1'b0, 'h00, 0};
    tv[1] = '{1'b0, 1'b1, 1'b0, 'h00, 1};
    tv[2] = '{1'b0, 1'b1, 1'b1, 'h11, 2};
    tv[3] = '{1'b0, 1'b1, 1'b1, 'h12, 2};
    tv[4] = '{1'b0, 1'b1, 1'b1, 'h13, 2};
    tv[5] = '{1'b0, 1'b0, 1'b1, 'h14, 2};
    tv[6] = '{1'b0, 1'b0, 1'b1, 'h15, 1};
    tv[7] = '{1'b0, 1'b0, 1'b0, -1, 0};
    for (int k = 0; k < NK; k++) begin
      hold[k] = 1'b1;
      m_ready[k] = 1'b0;
      loaded[k] = 0;
`ifdef EHL_FIFO_RD_PREFETCH_FLUSH_EN
      flush[k] = 1'b0;
`endif
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int k = 0; k < NK; k++) begin
      chk("rst_valid", m_valid[k], 0);
      chk("rst_level", level[k], 0);
      chk("rst_rd", fifo_rd[k], 0);
      chk("rst_data", m_data[k], 0);
    end
    // RD_LATENCY=1 streaming five words with m_ready held high
    load(1, 5, 'h11);
    m_ready[1] = 1'b1;
    for (int v = 0; v < 8; v++) begin
      hold[1] = tv[v].hold;
      #1;
      chk("t1_rd", fifo_rd[1], tv[v].exp_rd);
      chk("t1_valid", m_valid[1], tv[v].exp_valid);
      chk("t1_level", level[1], tv[v].exp_level);
      if (tv[v].exp_data >= 0) chk("t1_data", m_data[1], tv[v].exp_data);
      tick();
    end
    chk("t1_pulses", gd[1].pulses, 5);
    hold[1] = 1'b1;
    m_ready[1] = 1'b0;
    // RD_LATENCY=2 backpressure: fill stops at four, then drains without gaps
    load(2, 10, 'h20);
    hold[2] = 1'b0;
    repeat (8) tick();
    chk("t2_pulses", gd[2].pulses, 4);
    chk("t2_level", level[2], 4);
    chk("t2_valid", m_valid[2], 1);
    chk("t2_data", m_data[2], 'h20);
    repeat (3) tick();
    chk("t2_hold", m_valid[2] ? int'(m_data[2]) : -1, 'h20);
    m_ready[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t2_order", m_valid[2] ? int'(m_data[2]) : -1, 'h20 + i);
      tick();
    end
    chk("t2_total", gd[2].pulses, 10);
    m_ready[2] = 1'b0;
    hold[2] = 1'b1;
    // RD_LATENCY=0 capture and pop on the same edge at occ=1
    load(0, 30, 'h40);
    m_ready[0] = 1'b1;
    hold[0] = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t3_level", level[0], 1);
      chk("t3_data", m_valid[0] ? int'(m_data[0]) : -1, 'h40 + i);
      tick();
    end
    hold[0] = 1'b1;
    repeat (2) tick();
    // toggling m_ready with the FIFO racing to empty, scoreboarded per latency
    sb[0] = gd[0].rd_cnt;
    sb[1] = gd[1].rd_cnt;
    sb[2] = gd[2].rd_cnt;
    sb[3] = gd[3].rd_cnt;
    for (int k = 0; k < NK; k++) nextw[k] = 'hA0;
    for (int cyc = 0; cyc < 560; cyc++) begin
      for (int k = 0; k < NK; k++) begin
        if (cyc < 360) begin
          m_ready[k] = 1'(cyc % 2);
          hold[k] = $urandom_range(0, 3) == 0;
          if ($urandom_range(0, 4) == 0 && loaded[k] < 240) begin
            n = $urandom_range(1, 3);
            load(k, n, nextw[k]);
            nextw[k] += n;
          end
        end else begin
          m_ready[k] = 1'b1;
          hold[k] = 1'b0;
        end
      end
      #1;
      for (int k = 0; k < NK; k++)
        if (m_valid[k] && m_ready[k]) begin
          chk("t4_data", m_data[k], words[k][sb[k]]);
          sb[k]++;
        end
      tick();
    end
    for (int k = 0; k < NK; k++) chk("t4_delivered", sb[k], loaded[k]);
    // reset with occ=2 and one word in flight
    for (int k = 0; k < NK; k++) hold[k] = 1'b1;
    m_ready[1] = 1'b0;
    load(1, 5, 'h60);
    hold[1] = 1'b0;
    repeat (3) tick();
    chk("t5_pre_level", level[1], 3);
    hold[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_rd", fifo_rd[1], 0);
    chk("t5_valid", m_valid[1], 0);
    chk("t5_level", level[1], 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_valid_rel", m_valid[1], 0);
    chk("t5_level_rel", level[1], 0);
    tick();
    chk("t5_no_capture", m_valid[1], 0);
    chk("t5_level_after", level[1], 0);
`ifdef EHL_FIFO_RD_PREFETCH_FLUSH_EN
    // RD_LATENCY=3 flush with occ=3 and two words in flight
    m_ready[3] = 1'b0;
    load(3, 10, 'h80);
    hold[3] = 1'b0;
    repeat (6) tick();
    chk("fl_pre_level", level[3], 5);
    chk("fl_pre_data", m_data[3], 'h80);
    flush[3] = 1'b1;
    #1;
    chk("fl_rd", fifo_rd[3], 0);
    tick();
    flush[3] = 1'b0;
    #1;
    chk("fl_valid", m_valid[3], 0);
    chk("fl_level", level[3], 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (m_valid[3]) seen = 1'b1;
      else tick();
    end
    chk("fl_seen", seen, 1);
    chk("fl_data", m_data[3], 'h85);
`endif
    chk("uf0", gd[0].uf, 0);
    chk("uf1", gd[1].uf, 0);
    chk("uf2", gd[2].uf, 0);
    chk("uf3", gd[3].uf, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
